multicycle_cu: RTL and testbench

Complete multicycle control unit for the RISC-V core: state register, next-state logic, and control-signal generation in one block. It drives the shared datapath (PC, IR, memory port, register file, ALU muxes). It generalises the fixed ten-state MIPS-style decoder in three ways: it adds RV32I jump, immediate and LUI states, a memory ready handshake with a parametrised timeout, and a sticky fault state.

---
 rtl/cu_pkg.sv | 68 ++++++
 rtl/cu_output_decoder.sv | 81 ++++++++
 rtl/multicycle_cu.sv | 121 ++++++++++++
 tb/tb_multicycle_cu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// RV32I opcodes, datapath mux-select codes and the control bundle.
package cu_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JAL       = 4'd9,
        EXEC_I    = 4'd10,
        JALR      = 4'd11,
        LUI       = 4'd12,
        FAULT     = 4'd15
    } cuState_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;
    localparam logic [1:0] MTR_IMM    = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_ITYPE  = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BIMM  = 2'b11;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regWrite;
        logic [1:0] memToReg;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
    } cuCtrl_t;

endpackage

// File: rtl/cu_output_decoder.sv
// Combinational control-signal decode from the current state; only the
// FETCH strobes look at memReady.
module cu_output_decoder
    import cu_pkg::*;
(
    input  cuState_e curState,
    input  logic     memReady,
    output cuCtrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (curState)
            FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.irWrite = memReady;
                ctrl.pcWrite = memReady;
            end
            DECODE: begin
                ctrl.aluSrcA = SRCA_OLDPC;
                ctrl.aluSrcB = SRCB_BIMM;
            end
            MEM_ADDR: begin
                ctrl.aluSrcA = SRCA_RS1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            MEM_READ: begin
                ctrl.iOrD    = 1'b1;
                ctrl.memRead = 1'b1;
            end
            MEM_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = MTR_MDR;
            end
            MEM_WRITE: begin
                ctrl.iOrD     = 1'b1;
                ctrl.memWrite = 1'b1;
            end
            EXEC_R: begin
                ctrl.aluSrcA = SRCA_RS1;
                ctrl.aluOp   = ALU_RTYPE;
            end
            EXEC_I: begin
                ctrl.aluSrcA = SRCA_RS1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ITYPE;
            end
            ALU_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = MTR_ALUOUT;
            end
            BRANCH: begin
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCS_ALUOUT;
                ctrl.aluSrcA     = SRCA_RS1;
                ctrl.aluOp       = ALU_BRANCH;
            end
            JAL: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCS_ALUOUT;
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = MTR_PC;
            end
            JALR: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCS_ALU;
                ctrl.aluSrcA  = SRCA_RS1;
                ctrl.aluSrcB  = SRCB_IMM;
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = MTR_PC;
            end
            LUI: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = MTR_IMM;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle RV32I control unit: state register, memory-wait timeout,
// next-state logic and the control outputs driving the shared datapath.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned WAIT_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] state,
    output logic       fault,
    output logic       instr_done
);

    cuState_e          curState;
    cuState_e          nxtState;
    logic              isLoad;
    logic [WAIT_W-1:0] waitCnt;
    logic              inMemState;
    logic              timedOut;
    logic              readyQual;
    cuCtrl_t           ctrl;

    assign inMemState = (curState == FETCH) || (curState == MEM_READ) ||
                        (curState == MEM_WRITE);
    assign timedOut   = (TIMEOUT != 0) && (waitCnt == WAIT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState <= FETCH;
            isLoad   <= 1'b0;
            waitCnt  <= '0;
        end else begin
            curState <= nxtState;
            if (curState == DECODE) begin
                isLoad <= (opcode == OP_LOAD);
            end
            // Any state change is an entry into a new state, so the count restarts.
            if (nxtState != curState) begin
                waitCnt <= '0;
            end else if (inMemState && !mem_ready) begin
                waitCnt <= waitCnt + WAIT_W'(1);
            end
        end
    end

    always_comb begin
        nxtState = curState;
        case (curState)
            FETCH: begin
                if (mem_ready)     nxtState = DECODE;
                else if (timedOut) nxtState = FAULT;
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxtState = MEM_ADDR;
                    OP_RTYPE:          nxtState = EXEC_R;
                    OP_ITYPE:          nxtState = EXEC_I;
                    OP_BRANCH:         nxtState = BRANCH;
                    OP_JAL:            nxtState = JAL;
                    OP_JALR:           nxtState = JALR;
                    OP_LUI:            nxtState = LUI;
                    default:           nxtState = FAULT;
                endcase
            end
            MEM_ADDR: nxtState = isLoad ? MEM_READ : MEM_WRITE;
            MEM_READ: begin
                if (mem_ready)     nxtState = MEM_WB;
                else if (timedOut) nxtState = FAULT;
            end
            MEM_WRITE: begin
                if (mem_ready)     nxtState = FETCH;
                else if (timedOut) nxtState = FAULT;
            end
            EXEC_R, EXEC_I: nxtState = ALU_WB;
            MEM_WB, ALU_WB, BRANCH, JAL, JALR, LUI: nxtState = FETCH;
            default: nxtState = FAULT;
        endcase
    end

    // Holding reset keeps the FETCH strobes low even if memory reports ready.
    assign readyQual = mem_ready & rst_n;

    cu_output_decoder u_dec (
        .curState (curState),
        .memReady (readyQual),
        .ctrl     (ctrl)
    );

    assign pc_write      = ctrl.pcWrite;
    assign pc_write_cond = ctrl.pcWriteCond;
    assign i_or_d        = ctrl.iOrD;
    assign mem_read      = ctrl.memRead;
    assign mem_write     = ctrl.memWrite;
    assign ir_write      = ctrl.irWrite;
    assign reg_write     = ctrl.regWrite;
    assign mem_to_reg    = ctrl.memToReg;
    assign pc_source     = ctrl.pcSource;
    assign alu_op        = ctrl.aluOp;
    assign alu_src_a     = ctrl.aluSrcA;
    assign alu_src_b     = ctrl.aluSrcB;
    assign state         = curState;
    assign fault         = (curState == FAULT);
    assign instr_done    = (nxtState == FETCH) && (curState != FETCH);

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed-vector bench for multicycle_cu; a second instance with a short
// timeout exercises the memory-wait fault path.
module tb_multicycle_cu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mr3;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b;
    logic [3:0] state;
    logic       fault, instr_done;

    logic       pcw3, pcwc3, iod3, mrd3, mwr3, irw3, rw3;
    logic [1:0] mtr3, pcs3, aop3, asa3, asb3;
    logic [3:0] state3;
    logic       fault3, done3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_cu dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_source(pc_source),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .state(state), .fault(fault), .instr_done(instr_done)
    );

    multicycle_cu #(.TIMEOUT(3), .WAIT_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mr3),
        .pc_write(pcw3), .pc_write_cond(pcwc3), .i_or_d(iod3),
        .mem_read(mrd3), .mem_write(mwr3), .ir_write(irw3),
        .reg_write(rw3), .mem_to_reg(mtr3), .pc_source(pcs3),
        .alu_op(aop3), .alu_src_a(asa3), .alu_src_b(asb3),
        .state(state3), .fault(fault3), .instr_done(done3)
    );

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; mr3 = 1'b1; opcode = 7'd0;
        #3;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL reset_mem_read: got %b expected 1", mem_read); end
        checks++; if (alu_src_b !== 2'b01) begin errors++; $display("FAIL reset_alu_src_b: got %b expected 01", alu_src_b); end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if ({reg_write, mem_write, i_or_d, alu_src_a} !== 5'b0) begin
            errors++; $display("FAIL reset_others: got %b expected 00000", {reg_write, mem_write, i_or_d, alu_src_a});
        end
        @(posedge clk); @(posedge clk); #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_hold_state: got %0d expected 0", state); end
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0;
    endtask

    task automatic test_rtype();
        logic [3:0] expSt [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        logic       mr    [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int doneCnt = 0;
        opcode = 7'b0110011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = mr[i]; #1;
            checks++; if (state !== expSt[i]) begin errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, expSt[i]); end
            if (instr_done === 1'b1) doneCnt++;
            if (i == 0) begin
                checks++; if ({ir_write, pc_write} !== 2'b11) begin errors++; $display("FAIL rtype_fetch_strobes: got %b expected 11", {ir_write, pc_write}); end
            end
            if (i == 2) begin
                checks++; if ({alu_src_a, alu_op} !== 4'b0110) begin errors++; $display("FAIL rtype_exec: got %b expected 0110", {alu_src_a, alu_op}); end
            end
            if (i == 3) begin
                checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL rtype_reg_write: got %b expected 1", reg_write); end
            end
            if (i == 4) begin
                checks++; if ({ir_write, pc_write} !== 2'b00) begin errors++; $display("FAIL rtype_fetch_stall: got %b expected 00", {ir_write, pc_write}); end
            end
        end
        checks++; if (doneCnt !== 1) begin errors++; $display("FAIL rtype_instr_done: got %0d pulses expected 1", doneCnt); end
    endtask

    task automatic test_load();
        logic [3:0] expSt [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        logic       mr    [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int doneCnt = 0;
        opcode = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); mem_ready = mr[i]; #1;
            checks++; if (state !== expSt[i]) begin errors++; $display("FAIL load_state[%0d]: got %0d expected %0d", i, state, expSt[i]); end
            if (instr_done === 1'b1) doneCnt++;
            if (i == 3) begin
                checks++; if ({i_or_d, mem_read} !== 2'b11) begin errors++; $display("FAIL load_mem_read: got %b expected 11", {i_or_d, mem_read}); end
            end
            if (i == 6) begin
                checks++; if ({reg_write, mem_to_reg} !== 3'b101) begin errors++; $display("FAIL load_wb: got %b expected 101", {reg_write, mem_to_reg}); end
            end
        end
        checks++; if (doneCnt !== 1) begin errors++; $display("FAIL load_instr_done: got %0d pulses expected 1", doneCnt); end
    endtask

    task automatic test_store_jal();
        logic [3:0] stSt [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        logic       stMr [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] jSt  [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
        opcode = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = stMr[i]; #1;
            checks++; if (state !== stSt[i]) begin errors++; $display("FAIL store_state[%0d]: got %0d expected %0d", i, state, stSt[i]); end
            if (i == 3) begin
                checks++; if ({i_or_d, mem_write, mem_read, instr_done} !== 4'b1101) begin
                    errors++; $display("FAIL store_write: got %b expected 1101", {i_or_d, mem_write, mem_read, instr_done});
                end
            end
        end
        opcode = 7'b1101111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = (i == 0); #1;
            checks++; if (state !== jSt[i]) begin errors++; $display("FAIL jal_state[%0d]: got %0d expected %0d", i, state, jSt[i]); end
            if (i == 2) begin
                checks++; if ({pc_write, pc_source, mem_to_reg, reg_write} !== 6'b101101) begin
                    errors++; $display("FAIL jal_ctrl: got %b expected 101101", {pc_write, pc_source, mem_to_reg, reg_write});
                end
            end
        end
    endtask

    task automatic test_dispatch();
        logic [6:0] ops  [4] = '{7'b0010011, 7'b1100011, 7'b1100111, 7'b0110111};
        logic [3:0] st2  [4] = '{4'd10, 4'd8, 4'd11, 4'd12};
        logic [5:0] sig  [4] = '{6'b001100, 6'b100100, 6'b010010, 6'b000011};
        for (int k = 0; k < 4; k++) begin
            bit back;
            opcode = ops[k];
            @(negedge clk); mem_ready = 1'b1; #1;
            @(negedge clk); mem_ready = 1'b0; #1;
            checks++; if (state !== 4'd1) begin errors++; $display("FAIL dispatch_decode[%0d]: got %0d expected 1", k, state); end
            @(negedge clk); #1;
            checks++; if (state !== st2[k]) begin errors++; $display("FAIL dispatch_state[%0d]: got %0d expected %0d", k, state, st2[k]); end
            checks++; if ({pc_write_cond, pc_write, alu_op, mem_to_reg} !== sig[k]) begin
                errors++; $display("FAIL dispatch_ctrl[%0d]: got %b expected %b", k, {pc_write_cond, pc_write, alu_op, mem_to_reg}, sig[k]);
            end
            back = 1'b0;
            for (int c = 0; c < 3 && !back; c++) begin
                @(negedge clk); #1;
                if (state === 4'd0) back = 1'b1;
            end
            checks++; if (!back) begin errors++; $display("FAIL dispatch_return[%0d]: got state %0d expected 0 within 3 cycles", k, state); end
        end
    endtask

    task automatic test_illegal();
        int faultCycles = 0;
        opcode = 7'b1111111;
        @(negedge clk); mem_ready = 1'b1; #1;
        @(negedge clk); #1;
        checks++; if (state !== 4'd1 || fault !== 1'b0) begin errors++; $display("FAIL illegal_decode: got state %0d fault %b expected 1/0", state, fault); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd15 || fault !== 1'b1) begin errors++; $display("FAIL illegal_fault: got state %0d fault %b expected 15/1", state, fault); end
        checks++; if ({mem_read, alu_src_b, pc_write, reg_write, instr_done} !== 6'b0) begin
            errors++; $display("FAIL illegal_outputs: got %b expected 000000", {mem_read, alu_src_b, pc_write, reg_write, instr_done});
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (state === 4'd15 && fault === 1'b1) faultCycles++;
        end
        checks++; if (faultCycles !== 20) begin errors++; $display("FAIL illegal_sticky: got %0d cycles expected 20", faultCycles); end
        #2 rst_n = 1'b0; #1;
        checks++; if (state !== 4'd0 || fault !== 1'b0) begin errors++; $display("FAIL illegal_reset: got state %0d fault %b expected 0/0", state, fault); end
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0;
    endtask

    task automatic test_timeout();
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; mr3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++; if (state3 !== 4'd0) begin errors++; $display("FAIL timeout_wait[%0d]: got %0d expected 0", c, state3); end
        end
        @(negedge clk); #1;
        checks++; if (state3 !== 4'd15 || fault3 !== 1'b1) begin errors++; $display("FAIL timeout_fault: got state %0d fault %b expected 15/1", state3, fault3); end

        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; mr3 = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk); mr3 = 1'b1; #1;
        checks++; if (irw3 !== 1'b1) begin errors++; $display("FAIL timeout_race_strobe: got %b expected 1", irw3); end
        @(negedge clk); mr3 = 1'b0; #1;
        checks++; if (state3 !== 4'd1 || fault3 !== 1'b0) begin errors++; $display("FAIL timeout_race: got state %0d fault %b expected 1/0", state3, fault3); end
    endtask

    task automatic test_async_reset();
        int doneCnt = 0;
        opcode = 7'b0110011;
        @(negedge clk); mem_ready = 1'b1; #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        @(negedge clk); #1;
        checks++; if (state !== 4'd6) begin errors++; $display("FAIL async_exec: got %0d expected 6", state); end
        #1 rst_n = 1'b0; #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL async_state: got %0d expected 0", state); end
        checks++; if (instr_done !== 1'b0 || reg_write !== 1'b0) begin
            errors++; $display("FAIL async_outputs: got done %b reg_write %b expected 0/0", instr_done, reg_write);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            if (instr_done === 1'b1 || reg_write === 1'b1) doneCnt++;
        end
        checks++; if (doneCnt !== 0) begin errors++; $display("FAIL async_no_retire: got %0d retire cycles expected 0", doneCnt); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load();
        test_store_jal();
        test_dispatch();
        test_illegal();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
